// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the bit-serial link.
// Used by both the transmitter and the receiver side.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-WIDTH bit position counter for serial frames.
// Synchronous clear, asynchronous reset, wraps after WIDTH-1.
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          is_first,
  output logic          is_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= is_last ? '0 : count + 1'b1;
    end
  end

  assign is_first = (count == '0);
  assign is_last  = (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter with valid/ready load.
// Back-to-back words are accepted on the last-bit cycle.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last
);

  localparam int CW = cnt_w(WIDTH);
  localparam int OB = LSB_FIRST ? 0 : WIDTH - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CW-1:0]    count;
  logic             is_first;
  logic             is_last;
  logic             frame_end;
  logic             hs;
  logic             shifting;

  assign shifting  = (state_q == SHIFT);
  assign frame_end = shifting && (count == LAST_CNT);
  assign hs        = load_valid && load_ready;

  serial_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (hs),
    .inc      (shifting),
    .count    (count),
    .is_first (is_first),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_d = SHIFT;
      end
      SHIFT: begin
        load_ready = frame_end;
        if (frame_end && !load_valid) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (hs) begin
      sr_d = load_data;
    end else if (shifting) begin
      sr_d = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    end
  end

  // One flop per bit so each stage clears independently on rst.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q[i] <= 1'b0;
      end else begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  assign sout       = shifting && sr_q[OB];
  assign sout_valid = shifting;
  assign sout_first = shifting && is_first;
  assign sout_last  = shifting && is_last;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed frames plus a
// randomized stream checked against a frame-level model.
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic       rst_a, lv_a, lr_a, so_a, sv_a, sf_a, sl_a;
  logic [7:0] ld_a;
  logic       rst_b, lv_b, lr_b, so_b, sv_b, sf_b, sl_b;
  logic [7:0] ld_b;
  logic       rst_c, lv_c, lr_c, so_c, sv_c, sf_c, sl_c;
  logic [0:0] ld_c;

  serial_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .load_valid(lv_a), .load_data(ld_a),
    .load_ready(lr_a), .sout(so_a), .sout_valid(sv_a),
    .sout_first(sf_a), .sout_last(sl_a)
  );

  serial_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .load_valid(lv_b), .load_data(ld_b),
    .load_ready(lr_b), .sout(so_b), .sout_valid(sv_b),
    .sout_first(sf_b), .sout_last(sl_b)
  );

  serial_tx #(.WIDTH(1), .LSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst_c), .load_valid(lv_c), .load_data(ld_c),
    .load_ready(lr_c), .sout(so_c), .sout_valid(sv_c),
    .sout_first(sf_c), .sout_last(sl_c)
  );

  // Expected {load_ready, sout, sout_valid, sout_first, sout_last}
  // for bit position idx of word w in an 8-bit frame.
  function automatic logic [4:0] frame_exp(input logic [7:0] w,
                                           input int idx,
                                           input bit lsb);
    int pos;
    logic b;
    pos = lsb ? idx : 7 - idx;
    b = ((w >> pos) & 8'd1) != 0;
    return {idx == 7, b, 1'b1, idx == 0, idx == 7};
  endfunction

  localparam logic [4:0] IDLE_OUT = 5'b10000;

  task automatic test_reset();
    rst_a = 1; rst_b = 1; rst_c = 1;
    lv_a = 1; ld_a = 8'($urandom);
    lv_b = 1; ld_b = 8'($urandom);
    lv_c = 1; ld_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({lr_a, so_a, sv_a, sf_a, sl_a} !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_a got=%b exp=%b",
               {lr_a, so_a, sv_a, sf_a, sl_a}, IDLE_OUT);
    end
    n_cmp++;
    if ({lr_b, so_b, sv_b, sf_b, sl_b} !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_b got=%b exp=%b",
               {lr_b, so_b, sv_b, sf_b, sl_b}, IDLE_OUT);
    end
    n_cmp++;
    if ({lr_c, so_c, sv_c, sf_c, sl_c} !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL reset_c got=%b exp=%b",
               {lr_c, so_c, sv_c, sf_c, sl_c}, IDLE_OUT);
    end
    lv_b = 0; lv_c = 0;
  endtask

  task automatic test_single_frame();
    logic [4:0] exp;
    rst_a = 0; rst_b = 0; rst_c = 0;
    lv_a = 1; ld_a = 8'hA5;
    @(posedge clk);
    #1 lv_a = 0; ld_a = 8'($urandom);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      exp = (cyc <= 8) ? frame_exp(8'hA5, cyc - 1, 1'b1) : IDLE_OUT;
      n_cmp++;
      if ({lr_a, so_a, sv_a, sf_a, sl_a} !== exp) begin
        n_bad++;
        $display("FAIL single_frame cyc=%0d got=%b exp=%b", cyc,
                 {lr_a, so_a, sv_a, sf_a, sl_a}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    lv_a = 1; ld_a = 8'hA5;
    @(posedge clk);
    #1 ld_a = 8'h3C;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      if (cyc == 9) lv_a = 0;
      if (cyc <= 8)
        exp = frame_exp(8'hA5, cyc - 1, 1'b1);
      else if (cyc <= 16)
        exp = frame_exp(8'h3C, cyc - 9, 1'b1);
      else
        exp = IDLE_OUT;
      n_cmp++;
      if ({lr_a, so_a, sv_a, sf_a, sl_a} !== exp) begin
        n_bad++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc,
                 {lr_a, so_a, sv_a, sf_a, sl_a}, exp);
      end
    end
  endtask

  task automatic test_ignored_loads();
    logic [4:0] exp;
    lv_a = 1; ld_a = 8'hA5;
    @(posedge clk);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      exp = (cyc <= 8) ? frame_exp(8'hA5, cyc - 1, 1'b1) : IDLE_OUT;
      n_cmp++;
      if ({lr_a, so_a, sv_a, sf_a, sl_a} !== exp) begin
        n_bad++;
        $display("FAIL ignored_loads cyc=%0d got=%b exp=%b", cyc,
                 {lr_a, so_a, sv_a, sf_a, sl_a}, exp);
      end
      lv_a = (cyc < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      ld_a = 8'($urandom);
    end
  endtask

  task automatic test_msb_first();
    logic [4:0] exp;
    lv_b = 1; ld_b = 8'h80;
    @(posedge clk);
    #1 lv_b = 0; ld_b = 8'($urandom);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      exp = (cyc <= 8) ? frame_exp(8'h80, cyc - 1, 1'b0) : IDLE_OUT;
      n_cmp++;
      if ({lr_b, so_b, sv_b, sf_b, sl_b} !== exp) begin
        n_bad++;
        $display("FAIL msb_first cyc=%0d got=%b exp=%b", cyc,
                 {lr_b, so_b, sv_b, sf_b, sl_b}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp;
    lv_a = 1; ld_a = 8'hA5;
    @(posedge clk);
    #1 lv_a = 0;
    repeat (3) @(negedge clk);
    exp = frame_exp(8'hA5, 2, 1'b1);
    n_cmp++;
    if ({lr_a, so_a, sv_a, sf_a, sl_a} !== exp) begin
      n_bad++;
      $display("FAIL pre_reset_bit3 got=%b exp=%b",
               {lr_a, so_a, sv_a, sf_a, sl_a}, exp);
    end
    #1 rst_a = 1;
    #1;
    n_cmp++;
    if ({lr_a, so_a, sv_a, sf_a, sl_a} !== IDLE_OUT) begin
      n_bad++;
      $display("FAIL async_reset got=%b exp=%b",
               {lr_a, so_a, sv_a, sf_a, sl_a}, IDLE_OUT);
    end
    @(negedge clk);
    rst_a = 0; lv_a = 1; ld_a = 8'hFF;
    @(posedge clk);
    #1 lv_a = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      exp = (cyc <= 8) ? frame_exp(8'hFF, cyc - 1, 1'b1) : IDLE_OUT;
      n_cmp++;
      if ({lr_a, so_a, sv_a, sf_a, sl_a} !== exp) begin
        n_bad++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc,
                 {lr_a, so_a, sv_a, sf_a, sl_a}, exp);
      end
    end
  endtask

  task automatic test_width1();
    logic [4:0] exp;
    lv_c = 1; ld_c = 1'b1;
    @(posedge clk);
    #1 ld_c = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      case (cyc)
        1:       exp = 5'b11111;
        2:       exp = 5'b10111;
        default: exp = IDLE_OUT;
      endcase
      n_cmp++;
      if ({lr_c, so_c, sv_c, sf_c, sl_c} !== exp) begin
        n_bad++;
        $display("FAIL width1 cyc=%0d got=%b exp=%b", cyc,
                 {lr_c, so_c, sv_c, sf_c, sl_c}, exp);
      end
      if (cyc == 1) begin
        @(posedge clk);
        #1 lv_c = 0;
      end
    end
  endtask

  // Frame-level model: a word in flight and the index of the bit on
  // the line; a new word is taken when idle or on the final bit.
  task automatic test_random_stream();
    bit         busy = 0;
    logic [7:0] word = '0;
    int         idx = 0;
    bit         ready;
    logic [4:0] exp;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      exp = busy ? frame_exp(word, idx, 1'b1) : IDLE_OUT;
      n_cmp++;
      if ({lr_a, so_a, sv_a, sf_a, sl_a} !== exp) begin
        n_bad++;
        $display("FAIL random_stream cyc=%0d got=%b exp=%b", cyc,
                 {lr_a, so_a, sv_a, sf_a, sl_a}, exp);
      end
      lv_a = ($urandom_range(0, 9) < 7);
      ld_a = 8'($urandom);
      ready = !busy || idx == 7;
      if (lv_a && ready) begin
        busy = 1; word = ld_a; idx = 0;
      end else if (busy) begin
        if (idx == 7) busy = 0;
        else idx++;
      end
    end
    lv_a = 0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_loads();
    test_msb_first();
    test_async_reset();
    test_width1();
    test_random_stream();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

- Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready load handshake and shifts it out one bit per clock.
- Transmitting end of the team's bit-serial links. It drives the same serial stream that the flip-flop-based serial receivers capture, using the same serial datapath style.
- Built from single-bit registers with asynchronous clear, plus a bit counter and a two-state controller.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range 1..32.
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- load_valid  input  1  load_data is presented for transmission.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- load_ready  output  1  transmitter can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- sout_first  output  1  current bit is the first bit of the frame.
- sout_last  output  1  current bit is the last bit of the frame.

## Operation
- States: IDLE, SHIFT.
- Handshake: a word is accepted on a posedge where load_valid && load_ready.
- IDLE:
  - load_ready = 1.
  - On handshake: capture load_data into the shift register, clear bit counter to 0, go to SHIFT.
- SHIFT:
  - sout_valid = 1.
  - sout = register bit 0 if LSB_FIRST, else bit WIDTH-1.
  - Each cycle the register shifts toward the output end, zero-filling, and the counter increments.
  - sout_first = (count == 0); sout_last = (count == WIDTH-1).
- Last-bit cycle (count == WIDTH-1):
  - load_ready = 1.
  - On handshake: load the new word, reset count to 0, stay in SHIFT. This gives zero-gap back-to-back frames.
  - No handshake: go to IDLE.
- load_ready = 0 in every other SHIFT cycle. load_valid and load_data are ignored there, and the frame is never corrupted.
- Counter width: $clog2(WIDTH) bits, minimum 1. For WIDTH=1 every SHIFT cycle is both first and last.
- Outputs while not in SHIFT:
  - sout = 0, sout_valid = 0, sout_first = 0, sout_last = 0.
  - No X propagation from load_data.
- All outputs are combinational decodes of registered state, with no input-to-output combinational path except load_ready. load_ready depends only on state and count, never on load_valid.

## Timing
- Reset values:
  - state = IDLE, shift register = 0, count = 0.
  - load_ready = 1, sout = 0, sout_valid = 0, sout_first = 0, sout_last = 0.
- Latency: handshake at edge N puts the first bit on sout during cycle N+1 (after edge N). The last bit appears during cycle N+WIDTH.
- Throughput: one word per WIDTH cycles with continuous load_valid; 100% line utilisation.
- Reset mid-frame:
  - Asserting rst at any time aborts the frame asynchronously and forces reset values without waiting for clk.
  - The partial frame is discarded and never resumed.
- Release of rst: the first handshake is possible on the first posedge after release.
- load_valid asserted during reset has no effect.

## Structure
- Shared package serial_pkg holds:
  - state typedef (IDLE, SHIFT);
  - the counter-width function/constant derived from WIDTH, shared with the receiver side.
- One natural sub-module: serial_bit_counter, a modulo-WIDTH up-counter with synchronous clear and asynchronous rst. It outputs count, is_first and is_last.
- The shift register and FSM live in the top module.

## Test plan
- Reset then single frame: WIDTH=8, LSB_FIRST=1, load 8'hA5 at edge 0.
  - sout over cycles 1..8 = 1,0,1,0,0,1,0,1.
  - sout_first only in cycle 1, sout_last only in cycle 8.
  - sout_valid low and load_ready high from cycle 9.
- Back-to-back: load 8'hA5, hold load_valid with 8'h3C presented at the last-bit cycle.
  - 8'h3C bits 0,0,1,1,1,1,0,0 follow in cycles 9..16 with no gap and sout_valid continuously high.
- Ignored loads: while busy, toggle load_valid with random load_data.
  - Transmitted bits remain exactly 8'hA5.
  - load_ready is low for cycles 1..7.
- MSB-first: LSB_FIRST=0, load 8'h80.
  - sout = 1 in cycle 1, then 0 for cycles 2..8.
- Asynchronous reset mid-frame: assert rst between edges during bit 3.
  - All outputs take reset values before the next posedge.
  - After release, a new 8'hFF frame transmits eight 1s starting the cycle after its handshake.
- WIDTH=1 corner: load 1'b1 then 1'b0 back-to-back.
  - sout = 1 then 0, with sout_first and sout_last both high in each cycle.
